// File: rtl/ddr3_dm_lane_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_dm_lane_tx_ctrl_if
// Description : Bundle for the DDR3 DM lane transmit controller. It carries
//               the write-datapath handshake, the delay-line control and
//               status signals, and the IOD-facing lane signals.
//               master = write datapath / calibration side
//               slave  = ddr3_dm_lane_tx_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
interface ddr3_dm_lane_tx_ctrl_if #(
  parameter int TAP_W = 8
);

  // Write datapath
  logic [3:0]       wr_lat;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       wr_dm;

  // Delay-line sequencing
  logic             dly_req;
  logic [TAP_W-1:0] dly_tap;
  logic             dly_busy;
  logic             dly_done;
  logic             dly_err;
  logic [TAP_W-1:0] dly_cur_tap;

  // IOD side
  logic [7:0]       tx_data_0;
  logic [3:0]       oe_data_0;
  logic             odt_en_0;
  logic             delay_line_load_0;
  logic             delay_line_move_0;
  logic             delay_line_direction_0;
  logic             delay_line_out_of_range_0;

  modport master (
    output wr_lat, wr_valid, wr_dm, dly_req, dly_tap, delay_line_out_of_range_0,
    input  wr_ready, dly_busy, dly_done, dly_err, dly_cur_tap,
    input  tx_data_0, oe_data_0, odt_en_0,
    input  delay_line_load_0, delay_line_move_0, delay_line_direction_0
  );

  modport slave (
    input  wr_lat, wr_valid, wr_dm, dly_req, dly_tap, delay_line_out_of_range_0,
    output wr_ready, dly_busy, dly_done, dly_err, dly_cur_tap,
    output tx_data_0, oe_data_0, odt_en_0,
    output delay_line_load_0, delay_line_move_0, delay_line_direction_0
  );

endinterface
`default_nettype wire

// File: rtl/ddr3_dm_lane_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_dm_lane_tx_ctrl
// Description : Fabric-side driver for one DDR3 data-mask lane IOD. Delays
//               each accepted BL8 mask word by WR_LAT cycles and drives
//               TX_DATA/OE_DATA/ODT_EN, and sequences the IOD output delay
//               line (LOAD then MOVE steps) to a requested tap, blocking
//               writes while the sequence runs.
//               Optional feature macro: DDR3_DM_OE_PREAMBLE_EN adds a one
//               cycle OE/ODT preamble and postamble around each burst run.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_dm_lane_tx_ctrl #(
  parameter int MAX_LAT   = 16,
  parameter int TAP_W     = 8,
  parameter int STEP_GAP  = 2,
  parameter int LOAD_WAIT = 4
) (
  input  logic                  fab_clk,
  input  logic                  arst_n,
  ddr3_dm_lane_tx_ctrl_if.slave bus
);

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_LOAD  = 3'd2,
    S_LWAIT = 3'd3,
    S_STEP  = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [TAP_W-1:0] cur_tap, cur_tap_nxt;
  logic [TAP_W-1:0] target, target_nxt;
  logic             err_r, err_nxt;
  logic             dir_r;

  logic [MAX_LAT-1:0] pipe_vld;
  logic [7:0]         pipe_dm [MAX_LAT];
  logic               tx_vld_r;
  logic [7:0]         tx_dm_r;
  logic               oe_r;

  logic               accept;
  logic               load_vld;
  logic               oe_nxt;
  logic               pipe_empty;
  logic               drained;

  assign accept   = bus.wr_valid & bus.wr_ready;
  // Stage WR_LAT holds the word that moves into the output register next edge.
  assign load_vld = pipe_vld[bus.wr_lat];

  // Latency pipe: stage 0 captures the accepted word, every stage shifts each cycle.
  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < MAX_LAT; i++) pipe_dm[i] <= 8'h00;
    end else begin
      pipe_vld   <= {pipe_vld[MAX_LAT-2:0], accept};
      pipe_dm[0] <= accept ? bus.wr_dm : 8'h00;
      for (int i = 1; i < MAX_LAT; i++) pipe_dm[i] <= pipe_dm[i-1];
    end
  end

  // Output enable: burst cycles, plus optional preamble/postamble cycles.
  always_comb begin
    oe_nxt = load_vld;
`ifdef DDR3_DM_OE_PREAMBLE_EN
    // Preamble when the word one stage short of the tap will load next cycle;
    // postamble in the cycle after any burst. WR_LAT=0 has no preamble slot.
    if ((bus.wr_lat != 4'd0) && pipe_vld[bus.wr_lat - 4'd1]) oe_nxt = 1'b1;
    if (tx_vld_r) oe_nxt = 1'b1;
`endif
  end

  // Registered IOD drive: data only in burst cycles, zero otherwise.
  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      tx_vld_r <= 1'b0;
      tx_dm_r  <= 8'h00;
      oe_r     <= 1'b0;
    end else begin
      tx_vld_r <= load_vld;
      tx_dm_r  <= load_vld ? pipe_dm[bus.wr_lat] : 8'h00;
      oe_r     <= oe_nxt;
    end
  end

  // Stages beyond WR_LAT have already been handed to the output register.
  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < MAX_LAT; i++) begin
      if ((i <= int'(bus.wr_lat)) && pipe_vld[i]) pipe_empty = 1'b0;
    end
  end

  assign drained = pipe_empty & ~tx_vld_r & ~oe_r;

  // Direction reads 0 while in reset and 1 ever after (increment only).
  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) dir_r <= 1'b0;
    else         dir_r <= 1'b1;
  end

  // Sequencer state and working registers.
  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cur_tap <= '0;
      target  <= '0;
      err_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cur_tap <= cur_tap_nxt;
      target  <= target_nxt;
      err_r   <= err_nxt;
    end
  end

  // Sequencer next state and state-decoded outputs.
  always_comb begin
    state_nxt             = state;
    cnt_nxt               = cnt;
    cur_tap_nxt           = cur_tap;
    target_nxt            = target;
    err_nxt               = err_r;
    bus.wr_ready          = (state == S_IDLE);
    bus.dly_busy          = (state != S_IDLE);
    bus.dly_done          = (state == S_DONE);
    bus.delay_line_load_0 = (state == S_LOAD);
    // An out-of-range indication suppresses the step so the tap count holds.
    bus.delay_line_move_0 = (state == S_STEP) & ~bus.delay_line_out_of_range_0;

    case (state)
      S_IDLE: begin
        if (bus.dly_req) begin
          target_nxt = bus.dly_tap;
          err_nxt    = 1'b0;
          state_nxt  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        cur_tap_nxt = '0;
        cnt_nxt     = CNT_W'(LOAD_WAIT - 1);
        state_nxt   = S_LWAIT;
      end
      S_LWAIT: begin
        if (cnt == '0) state_nxt = (target == '0) ? S_DONE : S_STEP;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_STEP: begin
        if (bus.delay_line_out_of_range_0) begin
          err_nxt   = 1'b1;
          state_nxt = S_ERR;
        end else begin
          cur_tap_nxt = cur_tap + TAP_W'(1);
          cnt_nxt     = CNT_W'(STEP_GAP - 2);
          state_nxt   = S_GAP;
        end
      end
      S_GAP: begin
        if (bus.delay_line_out_of_range_0) begin
          err_nxt   = 1'b1;
          state_nxt = S_ERR;
        end else if (cnt == '0) begin
          state_nxt = (cur_tap == target) ? S_DONE : S_STEP;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.tx_data_0              = tx_dm_r;
  assign bus.oe_data_0              = {4{oe_r}};
  assign bus.odt_en_0               = oe_r;
  assign bus.dly_err                = err_r;
  assign bus.dly_cur_tap            = cur_tap;
  assign bus.delay_line_direction_0 = dir_r;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_dm_lane_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_dm_lane_tx_ctrl
// Description : Directed self-checking bench for ddr3_dm_lane_tx_ctrl.
//               Outputs are sampled 1 ns after the rising edge; inputs are
//               changed at that same point so the next edge samples them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_dm_lane_tx_ctrl;

`ifdef DDR3_DM_OE_PREAMBLE_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif
  localparam int STEP_GAP  = 2;
  localparam int LOAD_WAIT = 4;

  logic clk;
  logic arst_n;

  ddr3_dm_lane_tx_ctrl_if #(.TAP_W(8)) bus ();

  ddr3_dm_lane_tx_ctrl #(
    .MAX_LAT(16), .TAP_W(8), .STEP_GAP(STEP_GAP), .LOAD_WAIT(LOAD_WAIT)
  ) dut (
    .fab_clk (clk),
    .arst_n  (arst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Per-sequence observations
  int n_load, n_move, n_done, n_burst, n_oe_after_load;
  int load_idx, first_move_idx, last_burst_idx, gap_bad, ready_busy, dir_bad;
  int timed_out;
  logic       err_at_start;
  logic [7:0] burst_words [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tx"},    32'(bus.tx_data_0), 32'h00);
    check({tag, "_oe"},    32'(bus.oe_data_0), 32'h0);
    check({tag, "_odt"},   32'(bus.odt_en_0), 32'h0);
    check({tag, "_ready"}, 32'(bus.wr_ready), 32'h1);
    check({tag, "_busy"},  32'(bus.dly_busy), 32'h0);
    check({tag, "_done"},  32'(bus.dly_done), 32'h0);
    check({tag, "_err"},   32'(bus.dly_err), 32'h0);
    check({tag, "_tap"},   32'(bus.dly_cur_tap), 32'h0);
    check({tag, "_load"},  32'(bus.delay_line_load_0), 32'h0);
    check({tag, "_move"},  32'(bus.delay_line_move_0), 32'h0);
    check({tag, "_dir"},   32'(bus.delay_line_direction_0), 32'h0);
  endtask

  // Issue DLY_REQ on the next edge (cycle 0) and follow the sequence until
  // the block is idle again. Optionally raise OUT_OF_RANGE in the cycle after
  // the oor_after-th MOVE pulse.
  task automatic run_seq(input logic [7:0] tap, input int oor_after);
    int cyc;
    int last_move;
    bit fin;
    n_load = 0; n_move = 0; n_done = 0; n_burst = 0; n_oe_after_load = 0;
    load_idx = -1; first_move_idx = -1; last_burst_idx = -1;
    gap_bad = 0; ready_busy = 0; dir_bad = 0; timed_out = 0;
    last_move = -1; fin = 1'b0; cyc = 0;
    bus.dly_tap = tap;
    bus.dly_req = 1'b1;
    tick();
    bus.dly_req  = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_dm    = 8'h00;
    err_at_start = bus.dly_err;
    while (!fin && cyc < 100) begin
      tick();
      cyc++;
      if (bus.delay_line_direction_0 !== 1'b1) dir_bad++;
      if (bus.wr_ready && bus.dly_busy) ready_busy++;
      if (bus.delay_line_load_0) begin
        n_load++;
        load_idx = cyc;
      end
      if (bus.oe_data_0 != 4'h0 && n_load > 0) n_oe_after_load++;
      if (bus.oe_data_0 == 4'hF && bus.tx_data_0 != 8'h00) begin
        if (n_burst < 4) burst_words[n_burst] = bus.tx_data_0;
        n_burst++;
        last_burst_idx = cyc;
      end
      if (bus.delay_line_move_0) begin
        n_move++;
        if (last_move >= 0 && (cyc - last_move) != STEP_GAP) gap_bad++;
        if (first_move_idx < 0) first_move_idx = cyc;
        last_move = cyc;
      end else if (oor_after > 0 && n_move >= oor_after) begin
        bus.delay_line_out_of_range_0 = 1'b1;
      end
      if (bus.dly_done) n_done++;
      if (!bus.dly_busy) fin = 1'b1;
    end
    bus.delay_line_out_of_range_0 = 1'b0;
    timed_out = fin ? 0 : 1;
  endtask

  logic [7:0] words [4];
  int         stale;
  logic [7:0] exp_tx;
  logic       exp_oe;

  initial begin
    n_checks = 0;
    n_errors = 0;
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h04; words[3] = 8'h08;
    bus.wr_lat = 4'd0;
    bus.wr_valid = 1'b0;
    bus.wr_dm = 8'h00;
    bus.dly_req = 1'b0;
    bus.dly_tap = 8'h00;
    bus.delay_line_out_of_range_0 = 1'b0;

    // Reset state
    arst_n = 1'b1;
    #2 arst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset("rst");
    #2 arst_n = 1'b1;
    tick();
    check("dir_after_rst", 32'(bus.delay_line_direction_0), 32'h1);

    // 1: WR_LAT=3, single word lands on the 4th edge after acceptance
    bus.wr_lat = 4'd3;
    bus.wr_valid = 1'b1;
    bus.wr_dm = 8'hA5;
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_dm = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_tx = (k == 4) ? 8'hA5 : 8'h00;
      exp_oe = (k == 4) | (PRE_EN & ((k == 3) | (k == 5)));
      check($sformatf("t1_tx_k%0d", k), 32'(bus.tx_data_0), 32'(exp_tx));
      check($sformatf("t1_oe_k%0d", k), 32'(bus.oe_data_0), exp_oe ? 32'hF : 32'h0);
    end
    check("t1_odt_idle", 32'(bus.odt_en_0), 32'h0);

    // 2: WR_LAT=0, four back-to-back words form one contiguous run
    bus.wr_lat = 4'd0;
    for (int c = 0; c <= 6; c++) begin
      bus.wr_valid = (c < 4);
      bus.wr_dm    = (c < 4) ? words[c] : 8'h00;
      tick();
      exp_tx = (c >= 1 && c <= 4) ? words[c-1] : 8'h00;
      exp_oe = (c >= 1 && c <= 4) | (PRE_EN & (c == 5));
      check($sformatf("t2_tx_c%0d", c), 32'(bus.tx_data_0), 32'(exp_tx));
      check($sformatf("t2_oe_c%0d", c), 32'(bus.oe_data_0), exp_oe ? 32'hF : 32'h0);
      check($sformatf("t2_odt_c%0d", c), 32'(bus.odt_en_0), 32'(exp_oe));
    end
    repeat (3) tick();

    // 3: tap 5 with an idle pipe
    run_seq(8'd5, 0);
    check("t3_timeout", 32'(timed_out), 32'd0);
    check("t3_loads", 32'(n_load), 32'd1);
    check("t3_load_idx", 32'(load_idx), 32'd1);
    check("t3_moves", 32'(n_move), 32'd5);
    check("t3_load_to_move", 32'(first_move_idx - load_idx), 32'(LOAD_WAIT + 1));
    check("t3_gap_bad", 32'(gap_bad), 32'd0);
    check("t3_dones", 32'(n_done), 32'd1);
    check("t3_ready_busy", 32'(ready_busy), 32'd0);
    check("t3_dir_bad", 32'(dir_bad), 32'd0);
    check("t3_cur_tap", 32'(bus.dly_cur_tap), 32'd5);
    check("t3_err", 32'(bus.dly_err), 32'd0);
    check("t3_ready_end", 32'(bus.wr_ready), 32'd1);
    repeat (2) tick();

    // 4: tap 3 while WR_LAT=7 and two words are in flight
    bus.wr_lat = 4'd7;
    bus.wr_valid = 1'b1;
    bus.wr_dm = 8'h3C;
    tick();
    bus.wr_dm = 8'hC3;
    run_seq(8'd3, 0);
    check("t4_timeout", 32'(timed_out), 32'd0);
    check("t4_bursts", 32'(n_burst), 32'd2);
    check("t4_word0", 32'(burst_words[0]), 32'h3C);
    check("t4_word1", 32'(burst_words[1]), 32'hC3);
    check("t4_last_burst_idx", 32'(last_burst_idx), 32'd8);
    check("t4_load_after_burst", 32'(load_idx > last_burst_idx), 32'd1);
    check("t4_oe_after_load", 32'(n_oe_after_load), 32'd0);
    check("t4_moves", 32'(n_move), 32'd3);
    check("t4_dones", 32'(n_done), 32'd1);
    check("t4_cur_tap", 32'(bus.dly_cur_tap), 32'd3);
    repeat (2) tick();

    // 5: out-of-range after the 4th MOVE, then a clean tap-0 request
    bus.wr_lat = 4'd0;
    run_seq(8'd10, 4);
    check("t5_timeout", 32'(timed_out), 32'd0);
    check("t5_moves", 32'(n_move), 32'd4);
    check("t5_dones", 32'(n_done), 32'd0);
    check("t5_err", 32'(bus.dly_err), 32'd1);
    check("t5_cur_tap", 32'(bus.dly_cur_tap), 32'd4);
    check("t5_idle", 32'(bus.wr_ready), 32'd1);
    tick();
    check("t5_err_sticky", 32'(bus.dly_err), 32'd1);
    run_seq(8'd0, 0);
    check("t5b_err_cleared", 32'(err_at_start), 32'd0);
    check("t5b_timeout", 32'(timed_out), 32'd0);
    check("t5b_loads", 32'(n_load), 32'd1);
    check("t5b_moves", 32'(n_move), 32'd0);
    check("t5b_dones", 32'(n_done), 32'd1);
    check("t5b_cur_tap", 32'(bus.dly_cur_tap), 32'd0);
    check("t5b_err", 32'(bus.dly_err), 32'd0);
    repeat (2) tick();

    // 6a: asynchronous reset with two words in the latency pipe
    bus.wr_lat = 4'd7;
    bus.wr_valid = 1'b1;
    bus.wr_dm = 8'h5A;
    tick();
    bus.wr_dm = 8'h66;
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_dm = 8'h00;
    tick();
    #2 arst_n = 1'b0;
    #1 check_reset("t6a");
    repeat (2) @(posedge clk);
    #3 arst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.oe_data_0 != 4'h0 || bus.tx_data_0 != 8'h00) stale++;
    end
    check("t6a_stale", 32'(stale), 32'd0);

    // 6b: asynchronous reset while the sequencer sits in GAP
    bus.wr_lat = 4'd0;
    bus.dly_tap = 8'd5;
    bus.dly_req = 1'b1;
    tick();
    bus.dly_req = 1'b0;
    stale = 0;
    for (int c = 0; c < 20 && !bus.delay_line_move_0; c++) tick();
    check("t6b_move_seen", 32'(bus.delay_line_move_0), 32'd1);
    tick();
    check("t6b_in_gap_busy", 32'(bus.dly_busy), 32'd1);
    #2 arst_n = 1'b0;
    #1 check_reset("t6b");
    repeat (2) @(posedge clk);
    #3 arst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.dly_done || bus.dly_busy || bus.delay_line_move_0 || bus.oe_data_0 != 4'h0) stale++;
    end
    check("t6b_quiet", 32'(stale), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
